// File: rtl/mips8_pkg.sv
// Shared types and constants for the mips8 fetch front end.
// Entry layout, FSM states and fixed widths.
package mips8_pkg;

   localparam int ADDR_W = 8;
   localparam int INST_W = 16;
   localparam int DEPTH = 2;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
   localparam logic [INST_W-1:0] HALT_WORD = 16'hFFFF;

   typedef enum logic {
      FETCH,
      HALTED
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO; slot 0 is always the head.
// Push and pop may coincide when full; flush beats push.
module fetch_buffer
   import mips8_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t e0_q, e0_d;
   fetch_entry_t e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         full;
   logic         do_pop;
   logic         do_push;

   assign full    = (cnt_q == 2'(BUF_DEPTH));
   assign do_pop  = pop && (cnt_q != 2'd0);
   assign do_push = push && (!full || do_pop);

   // Next slot contents and occupancy; entries shift toward slot 0 on pop.
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  e0_d = push_entry;
               end else begin
                  e0_d = e1_q;
                  e1_d = push_entry;
               end
            end
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = push_entry;
               else e1_d = push_entry;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Slot and count registers; reset clears contents so the head reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign head  = e0_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC sequencer and FETCH/HALTED control in front of instruction memory.
// Feeds decode through a two-entry buffer with valid/ready handshake.
module instruction_fetch
   import mips8_pkg::*;
#(
   parameter logic [7:0]  RESET_PC  = mips8_pkg::RESET_PC,
   parameter logic [15:0] HALT_WORD = mips8_pkg::HALT_WORD,
   parameter int          DEPTH     = mips8_pkg::DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  imem_address,
   input  logic [15:0] imem_data,
   output logic        inst_valid,
   output logic [15:0] inst_data,
   output logic [7:0]  inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_target,
   output logic        halted
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   fetch_state_e      state_q, state_d;
   logic [1:0]        count;
   fetch_entry_t      head;
   fetch_entry_t      new_entry;
   logic              pop;
   logic              enq;

   assign pop = inst_valid && inst_ready;
   assign enq = (state_q == FETCH) && !redirect_valid &&
                ((count < 2'(DEPTH)) || pop);

   assign new_entry.inst = imem_data;
   assign new_entry.pc   = pc_q;

   // Redirect overrides sequential fetch; a HALT word parks the FSM.
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (redirect_valid) begin
         pc_d    = redirect_target;
         state_d = FETCH;
      end else if (enq) begin
         pc_d = pc_q + 8'd1;
         if (imem_data == HALT_WORD) state_d = HALTED;
      end
   end

   // PC and FSM state.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= FETCH;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   fetch_buffer #(
      .BUF_DEPTH(DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (enq),
      .push_entry(new_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

   assign imem_address = pc_q;
   assign inst_valid   = (count != 2'd0);
   assign inst_data    = head.inst;
   assign inst_pc      = head.pc;
   assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table vectors plus
// hand sequences for HALT and reset while halted and full.
module tb_instruction_fetch;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [7:0]  tgt;
      logic        ev;
      logic        hd;
      logic [7:0]  epc;
      logic [15:0] edat;
      logic [7:0]  eaddr;
      logic        eh;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  imem_address;
   logic [15:0] imem_data;
   logic        inst_valid;
   logic [15:0] inst_data;
   logic [7:0]  inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_target;
   logic        halted;

   logic [15:0] mem [256];
   vec_t        vecs [$];
   int          n_pass = 0;
   int          n_total = 0;
   int          step_no = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_address];

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_address   (imem_address),
      .imem_data      (imem_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .halted         (halted)
   );

   task automatic add(input logic rst, input logic rdy,
                      input logic rv, input logic [7:0] tgt,
                      input logic ev, input logic hd,
                      input logic [7:0] epc, input logic [15:0] edat,
                      input logic [7:0] eaddr, input logic eh);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
      v.ev = ev; v.hd = hd; v.epc = epc; v.edat = edat;
      v.eaddr = eaddr; v.eh = eh;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] got,
                      input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s step %0d: got %h want %h",
                    name, step_no, got, exp);
   endtask

   task automatic run(input vec_t v);
      reset           = v.rst;
      inst_ready      = v.rdy;
      redirect_valid  = v.rv;
      redirect_target = v.tgt;
      @(posedge clk);
      #1;
      chk("valid", 16'(inst_valid), 16'(v.ev));
      chk("addr", 16'(imem_address), 16'(v.eaddr));
      chk("halted", 16'(halted), 16'(v.eh));
      if (v.hd) begin
         chk("pc", 16'(inst_pc), 16'(v.epc));
         chk("data", inst_data, v.edat);
      end
      step_no++;
   endtask

   task automatic hs(input logic rst, input logic rdy,
                     input logic rv, input logic [7:0] tgt,
                     input logic ev, input logic hd,
                     input logic [7:0] epc, input logic [15:0] edat,
                     input logic [7:0] eaddr, input logic eh);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
      v.ev = ev; v.hd = hd; v.epc = epc; v.edat = edat;
      v.eaddr = eaddr; v.eh = eh;
      run(v);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      reset = 1'b1;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 8'h00;

      // streaming
      add(1, 0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 8'h00, 0);
      for (int i = 0; i < 9; i++)
         add(0, 1, 0, 8'h00, 1, 1, 8'(i), 16'h1000 + 16'(i),
             8'(i + 1), 0);
      // backpressure
      add(1, 0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 8'h00, 0);
      add(0, 0, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h02, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h1001, 8'h03, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h02, 16'h1002, 8'h04, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h03, 16'h1003, 8'h05, 0);
      // redirect with a full buffer and a simultaneous pop
      add(1, 0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 8'h00, 0);
      add(0, 0, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);
      add(0, 0, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h02, 0);
      add(0, 1, 1, 8'h40, 0, 0, 8'h00, 16'h0000, 8'h40, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h40, 16'h1040, 8'h41, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h41, 16'h1041, 8'h42, 0);
      // wrap through 8'hFF
      add(0, 1, 1, 8'hFE, 0, 0, 8'h00, 16'h0000, 8'hFE, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'hFE, 16'h10FE, 8'hFF, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'hFF, 16'h10FF, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);
      add(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h1001, 8'h02, 0);

      foreach (vecs[i]) run(vecs[i]);

      // HALT at 8'h03, drain, then resume by redirect
      mem[3] = 16'hFFFF;
      hs(1, 1, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 8'h00, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h1001, 8'h02, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h02, 16'h1002, 8'h03, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h03, 16'hFFFF, 8'h04, 1);
      hs(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h04, 1);
      hs(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h04, 1);
      hs(0, 1, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);

      // fill to two entries while halted, then reset with a redirect pending
      hs(0, 0, 1, 8'h02, 0, 0, 8'h00, 16'h0000, 8'h02, 0);
      hs(0, 0, 0, 8'h00, 1, 1, 8'h02, 16'h1002, 8'h03, 0);
      hs(0, 0, 0, 8'h00, 1, 1, 8'h02, 16'h1002, 8'h04, 1);
      hs(0, 0, 0, 8'h00, 1, 1, 8'h02, 16'h1002, 8'h04, 1);
      hs(1, 0, 1, 8'h55, 0, 1, 8'h00, 16'h0000, 8'h00, 0);
      hs(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1000, 8'h01, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter sequencer and prefetch buffer in front of `InstructionMemory`. It drives the 8-bit instruction address and captures the 16-bit instruction word returned combinationally. Instructions go to decode through a valid/ready handshake with a 2-entry buffer. It accepts branch/jump redirects and stops fetching after a HALT word.

## Interface
- `RESET_PC`, 8'h00, PC loaded on reset
- `HALT_WORD`, 16'hFFFF, instruction encoding that stops fetching
- `DEPTH`, 2, prefetch buffer entries (only 2 supported)

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high
- `imem_address` output 8: to `InstructionMemory.address`, always equals PC
- `imem_data` input 16: from `InstructionMemory.data`, combinational for the current `imem_address`
- `inst_valid` output 1: buffer head holds an instruction
- `inst_data` output 16: head instruction word
- `inst_pc` output 8: address the head word was fetched from
- `inst_ready` input 1: decode accepts head this cycle
- `redirect_valid` input 1: branch/jump taken, one-cycle pulse
- `redirect_target` input 8: new PC
- `halted` output 1: HALT fetched, no further fetches

## Operation
- State machine has two states, FETCH and HALTED. Reset enters FETCH.
- **pop** = `inst_valid & inst_ready`. The head is removed at the clock edge.
- **enq** = FETCH & !redirect_valid & (count<2 | pop). It writes {`imem_data`, PC} to the tail and sets PC <= PC+1, modulo 256 (255 wraps to 0).
- If enq and `imem_data`==HALT_WORD:
  - The HALT word is enqueued normally.
  - PC still increments.
  - Next state is HALTED.
- HALTED:
  - No enq; PC holds.
  - The buffer continues to drain via pop.
  - `halted`=1.
- **redirect_valid**, in any state:
  - Buffer flushes to count=0.
  - PC <= redirect_target.
  - State <= FETCH.
  - The fetch at the old PC that cycle is discarded.
  - A pop in the same cycle still counts as delivered to decode.
- Redirect has priority over enq and HALT detection. Reset has priority over everything.
- **Count update:** count' = count + enq - pop; count never exceeds 2.
- When count is 2 and pop occurs, enq is allowed that cycle, so throughput is 1 instruction/cycle while `inst_ready` is held.
- Outputs are driven from registers only, except `imem_address`, which is the PC register.

## Timing
- **Reset values:** PC=RESET_PC, `imem_address`=RESET_PC, count=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `halted`=0.
- **Fetch latency:** `inst_valid` rises one cycle after the enq edge.
  - After reset deasserts, edge 1 fetches RESET_PC, and `inst_valid`=1 after edge 1.
- **Redirect latency:** after the redirect edge, `imem_address`=target and `inst_valid`=0. The target instruction is valid after the next edge.
- **Stall:** with `inst_ready`=0, two words are fetched, then PC holds (count=2) and `inst_data`/`inst_pc` are stable until pop.
- **HALT:** `halted` rises on the edge that enqueues HALT_WORD.
- **Reset mid-operation:** reset aborts everything in one edge, including a pending redirect and a full buffer.
- **Wrap:** the word at 8'hFF is followed by the word at 8'h00 with no bubble.

## Structure
- Shared package `mips8_pkg`:
  - `ADDR_W`=8, `INST_W`=16
  - `HALT_WORD`
  - state enum {FETCH, HALTED}
  - the {inst, pc} entry struct
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO of entries, with ports `push`, `pop`, `flush`, `count`, and `head`.
  - It supports push+pop when full.
  - `flush` wins over `push`.
- `instruction_fetch` holds the PC, the FSM and the enq/redirect logic, and instantiates `fetch_buffer`.

## Test plan
- **Streaming:** memory words 0..8 = 16'h1000+i, `inst_ready`=1 after reset -> `inst_pc` 0,1,2,... on consecutive cycles, `inst_data`=16'h1000+pc, no bubbles.
- **Backpressure:** `inst_ready`=0 for 5 cycles after reset.
  - `imem_address` stops at 2 and count=2.
  - `inst_data` holds 16'h1000.
  - On release, pcs 0,1,2 are delivered back-to-back.
- **Redirect:** redirect_valid pulse with target 8'h40 while count=2 and `inst_ready`=1.
  - The head at pc 0 pops.
  - The buffer flushes.
  - Next cycle `inst_valid`=0 and `imem_address`=8'h40.
  - The cycle after, `inst_pc`=8'h40.
- **HALT:** word at 8'h03 = 16'hFFFF.
  - `halted`=1 after its enq.
  - `imem_address` holds 8'h04.
  - Pcs 0..3 drain, then `inst_valid`=0.
  - A later redirect to 8'h00 clears `halted` and resumes fetching.
- **Wrap:** redirect to 8'hFE with ready=1 -> `inst_pc` sequence FE, FF, 00, 01.
- **Reset mid-stream:** reset asserted with count=2 and HALTED -> after one edge all outputs are at reset values and `imem_address`=RESET_PC.
